// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, oversampling
// default and the baud_select -> clock divisor table.
package uart_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DIV_W          = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Clock cycles per sample_ENABLE at 100 MHz, round(100e6 / (16 * baud)).
  function automatic logic [DIV_W-1:0] baud_divisor(input logic [2:0] sel);
    logic [DIV_W-1:0] div;
    case (sel)
      3'b000:  div = 16'd20833;
      3'b001:  div = 16'd5208;
      3'b010:  div = 16'd1302;
      3'b011:  div = 16'd651;
      3'b100:  div = 16'd326;
      3'b101:  div = 16'd163;
      3'b110:  div = 16'd109;
      default: div = 16'd54;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/uart_transmitter_baud_controller.sv
// Free-running divisor counter producing a one-cycle sample_ENABLE every
// baud_divisor(baud_select) clocks; held at zero while reset is high.
module baud_controller
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       sample_ENABLE
);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_last;

  assign div_last      = baud_divisor(baud_select) - 16'd1;
  assign sample_ENABLE = (div_cnt == div_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == div_last) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, DATA_W bits LSB first, even parity, stop.
// Each bit spans OVERSAMPLE sample_ENABLE ticks of the gated baud_controller.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] Tx_DATA,
  input  logic [2:0]        baud_select,
  input  logic              Tx_WR,
  input  logic              Tx_EN,
  output logic              TxD,
  output logic              Tx_BUSY,
  output logic [2:0]        state
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int IDX_W  = $clog2(DATA_W);

  // Handshake: a write is taken on a rising edge with Tx_WR=1, Tx_EN=1 and
  // the FSM in IDLE; Tx_BUSY is the ready-inverse and Tx_WR is never queued.
  logic              accept;
  logic              baud_reset;
  logic              sample_enable;
  logic              bit_done;
  logic              last_bit;
  logic [TICK_W-1:0] tick_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [IDX_W-1:0]  next_idx;
  logic [DATA_W-1:0] data_q;
  logic              parity_q;
  logic [2:0]        baud_q;
  logic              txd_q;

  assign accept     = Tx_WR & Tx_EN & (state == ST_IDLE);
  assign baud_reset = reset | (state == ST_IDLE);
  assign bit_done   = sample_enable & (tick_cnt == TICK_W'(OVERSAMPLE - 1));
  assign last_bit   = (bit_idx == IDX_W'(DATA_W - 1));
  assign next_idx   = bit_idx + IDX_W'(1);

  assign TxD     = txd_q;
  assign Tx_BUSY = (state != ST_IDLE);

  // Divisor counter restarts from zero on the first cycle after accept.
  baud_controller u_baud (
    .clk           (clk),
    .reset         (baud_reset),
    .baud_select   (baud_q),
    .sample_ENABLE (sample_enable)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      txd_q    <= 1'b1;
      tick_cnt <= '0;
      bit_idx  <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
      baud_q   <= '0;
    end else if (state == ST_IDLE) begin
      txd_q    <= 1'b1;
      tick_cnt <= '0;
      bit_idx  <= '0;
      if (accept) begin
        data_q   <= Tx_DATA;
        parity_q <= ^Tx_DATA;
        baud_q   <= baud_select;
        txd_q    <= 1'b0;
        state    <= ST_START;
      end
    end else if (sample_enable) begin
      if (!bit_done) begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end else begin
        // Bit period over: present the next bit from the following cycle.
        tick_cnt <= '0;
        case (state)
          ST_START: begin
            state   <= ST_DATA;
            bit_idx <= '0;
            txd_q   <= data_q[0];
          end
          ST_DATA: begin
            if (last_bit) begin
              state <= ST_PARITY;
              txd_q <= parity_q;
            end else begin
              bit_idx <= next_idx;
              txd_q   <= data_q[next_idx];
            end
          end
          ST_PARITY: begin
            state <= ST_STOP;
            txd_q <= 1'b1;
          end
          default: begin
            state <= ST_IDLE;
            txd_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
